// File: rtl/timer.sv
// Unit timer: counts t_length units of TICK_DIV clocks, then pulses t_done; blink on t_flicker when TIMER_FLICKER_EN is defined.
// Latency: t_done is high during the cycle after edge E+N*TICK_DIV, or the cycle after the start edge when t_length=0.
// Backpressure: none; t_start is accepted on every edge and restarts any run in progress.
module timer #(
   parameter int TICK_DIV       = 1,
   parameter int FLICKER_WINDOW = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       t_start,
   input  logic [4:0] t_length,
   output logic       t_flicker,
   output logic       t_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

   if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
      $error("timer: TICK_DIV must be within 1..65535");
   end
   if (FLICKER_WINDOW < 0 || FLICKER_WINDOW > 31) begin : g_bad_flicker_window
      $error("timer: FLICKER_WINDOW must be within 0..31");
   end

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  cnt;
   logic [4:0]  cnt_nxt;
   logic [15:0] pre;
   logic [15:0] pre_nxt;
   logic        done_q;

   // A start wins over everything except reset, including the DONE->IDLE return.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pre_nxt   = pre;
      if (t_start) begin
         cnt_nxt   = t_length;
         pre_nxt   = 16'd0;
         state_nxt = (t_length == 5'd0) ? DONE : RUN;
      end else begin
         case (state)
            RUN: begin
               if (pre == PRE_MAX) begin
                  pre_nxt = 16'd0;
                  if (cnt <= 5'd1) begin
                     cnt_nxt   = 5'd0;
                     state_nxt = DONE;
                  end else begin
                     cnt_nxt = cnt - 5'd1;
                  end
               end else begin
                  pre_nxt = pre + 16'd1;
               end
            end
            DONE:    state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = 5'd0;
               pre_nxt   = 16'd0;
            end
         endcase
      end
   end

`ifdef TIMER_FLICKER_EN
   localparam logic [4:0] FLK_WIN = 5'(FLICKER_WINDOW);

   logic flk_q;
   logic flk_nxt;

   // Odd remaining counts inside the window give one toggle per unit.
   always_comb begin
      flk_nxt = (state_nxt == RUN) && (cnt_nxt <= FLK_WIN) && cnt_nxt[0];
   end

   assign t_flicker = flk_q;
`else
   assign t_flicker = 1'b0;
`endif

   // Outputs are flopped from the next-state decode so they track state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         pre    <= 16'd0;
         done_q <= 1'b0;
`ifdef TIMER_FLICKER_EN
         flk_q  <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         pre    <= pre_nxt;
         done_q <= (state_nxt == DONE);
`ifdef TIMER_FLICKER_EN
         flk_q  <= flk_nxt;
`endif
      end
   end

   assign t_done = done_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: main instance at TICK_DIV=1, second instance at TICK_DIV=3.
module tb_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       t_start;
   logic [4:0] t_length;
   logic       t_flicker;
   logic       t_done;
   logic       start3;
   logic [4:0] len3;
   logic       flk3;
   logic       done3;

   int total  = 0;
   int passes = 0;
   int fails  = 0;

`ifdef TIMER_FLICKER_EN
   localparam bit FLK_EN = 1'b1;
`else
   localparam bit FLK_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   timer #(.TICK_DIV(1), .FLICKER_WINDOW(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .t_start   (t_start),
      .t_length  (t_length),
      .t_flicker (t_flicker),
      .t_done    (t_done)
   );

   timer #(.TICK_DIV(3), .FLICKER_WINDOW(4)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .t_start   (start3),
      .t_length  (len3),
      .t_flicker (flk3),
      .t_done    (done3)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k = edges since the start edge; remaining count drops by one every div edges.
   function automatic logic exp_flk(input int k, input int done_at, input int cnt0, input int div);
      int c;
      c = cnt0 - k / div;
      return FLK_EN && (k < done_at) && (c <= 4) && (c % 2 == 1);
   endfunction

   // Leaves t_length scrambled afterwards: it must be ignored outside a start.
   task automatic start_pulse(input logic [4:0] len);
      t_length = len;
      t_start  = 1'b1;
      tick();
      t_start  = 1'b0;
      t_length = 5'h15;
   endtask

   task automatic observe(input string tag, input int done_at, input int cnt0, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         chk($sformatf("%s_done@%0d", tag, k), t_done, logic'(k == done_at));
         chk($sformatf("%s_flk@%0d", tag, k), t_flicker, exp_flk(k, done_at, cnt0, 1));
         tick();
      end
   endtask

   initial begin
      // Reset must beat a simultaneous zero-length start.
      reset    = 1'b1;
      t_start  = 1'b1;
      t_length = 5'd0;
      start3   = 1'b1;
      len3     = 5'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rst_done@%0d", i), t_done, 1'b0);
         chk($sformatf("rst_flk@%0d", i), t_flicker, 1'b0);
         chk($sformatf("rst_done3@%0d", i), done3, 1'b0);
      end
      reset   = 1'b0;
      t_start = 1'b0;
      start3  = 1'b0;
      tick();
      chk("idle_done", t_done, 1'b0);
      chk("idle_flk", t_flicker, 1'b0);

      start_pulse(5'd10);
      observe("len10", 10, 10, 14);

      start_pulse(5'd0);
      observe("len0", 0, 0, 3);

      // Reset while cnt=5 aborts silently.
      start_pulse(5'd10);
      observe("abort", 10, 10, 5);
      reset = 1'b1;
      tick();
      chk("abort_rst1_done", t_done, 1'b0);
      chk("abort_rst1_flk", t_flicker, 1'b0);
      tick();
      chk("abort_rst2_done", t_done, 1'b0);
      chk("abort_rst2_flk", t_flicker, 1'b0);
      reset = 1'b0;
      start_pulse(5'd20);
      observe("len20", 20, 20, 23);

      start_pulse(5'd10);
      observe("pre_restart", 10, 10, 4);
      start_pulse(5'd3);
      observe("restart", 3, 3, 10);

      // Start accepted in the DONE cycle itself.
      start_pulse(5'd2);
      observe("pre_done", 2, 2, 2);
      chk("in_done", t_done, 1'b1);
      start_pulse(5'd1);
      observe("from_done", 1, 1, 3);

      t_length = 5'd5;
      t_start  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("held_done@%0d", i), t_done, 1'b0);
         chk($sformatf("held_flk@%0d", i), t_flicker, 1'b0);
      end
      t_start  = 1'b0;
      t_length = 5'd0;
      observe("held_release", 5, 5, 7);

      start_pulse(5'd31);
      observe("len31", 31, 31, 33);

      len3   = 5'd2;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      len3   = 5'd9;
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("div3_done@%0d", k), done3, logic'(k == 6));
         chk($sformatf("div3_flk@%0d", k), flk3, exp_flk(k, 6, 2, 3));
         tick();
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
